dpb_port_arbiter: RTL
=====================

// Module: dpb_port_arbiter
// PURPOSE
//  Shares port A of the 4Kx8 nibble-split dual-port block RAM between two requesters.
//  Requester 0 is the CPU side and requester 1 is the loader/DMA side.
//  Fixed priority goes to requester 0, with an aging override so requester 1 cannot starve.
//  Issues at most one RAM access per clock and returns read data one cycle after grant,
//  tagged to the requester that issued it. Port B of the RAM is untouched.
// PARAMETERS
//  AW        12  RAM address width (4096 locations)
//  DW        8   data width (two 4-bit nibble banks)
//  MAX_WAIT  4   consecutive denied cycles of req1 before req1 is forced to win
//  WAIT_W    3   width of the aging counter; must hold MAX_WAIT
// PORTS
//  clk       in   1   single clock for the arbiter and RAM port A
//  reset     in   1   synchronous, active-high reset
//  req0/req1       in   1   access request; held with stable we/addr/wdata until gnt
//  we0/we1         in   1   1 = write, 0 = read
//  addr0/addr1     in   AW  word address
//  wdata0/wdata1   in   DW  write data
//  gnt0/gnt1       out  1   combinational; access is presented to RAM this cycle
//  rvalid0/rvalid1 out  1   one-cycle pulse; read data for that requester is on rdataN
//  rdata0/rdata1   out  DW  registered read data; holds until the next rvalid of that port
//  ram_ce    out  1   RAM port A clock enable (= gnt0|gnt1)
//  ram_oce   out  1   tied 1 (bypass read mode)
//  ram_wre   out  1   write enable of the granted request
//  ram_ad    out  AW  muxed address; driven from requester 0 when idle
//  ram_din   out  DW  muxed write data
//  ram_dout  in   DW  RAM port A data out, valid the cycle after a read CE
// BEHAVIOUR
//  - Grant rule (combinational, per cycle):
//      force1 = (wait_cnt == MAX_WAIT) & req1.
//      gnt1 = req1 & (~req0 | force1).
//      gnt0 = req0 & ~gnt1.
//  - gnt0 and gnt1 are never both 1. With no requests, ram_ce=0 and ram_wre=0.
//  - Aging counter wait_cnt:
//      increments when req1 & ~gnt1, saturating at MAX_WAIT;
//      clears on gnt1 and when ~req1.
//  - Read pipeline (registered): rd_pend <= gnt&~we and rd_own <= port id.
//    On the next cycle with rd_pend: rdata[rd_own] <= ram_dout and rvalid[rd_own] pulses.
//    The other port's rdata is unchanged. Read latency is 1 cycle from gnt.
//  - Writes complete at the gnt edge. No rvalid is produced for a write.
//  - Back-to-back accesses are allowed every cycle, including alternating owners.
//    The read pipeline is one deep, so a new read may be granted in the same cycle
//    that a previous read's rvalid fires.
//  - Handshake: the requester may change addr/we/wdata or drop req the cycle after gnt.
//    Keeping req high requests a new access.
//  - Write then read of the same address on consecutive cycles returns the new data
//    (RAM normal write mode).
//  - Reset, on the synchronous edge:
//      rvalid0/1 = 0, rdata0/1 = 0, rd_pend = 0, wait_cnt = 0.
//      gnt/ram_ce are gated low while reset=1.
//    A read granted in the cycle before reset asserts produces no rvalid.
//  - Requests presented while reset=1 are ignored and must be re-held after reset falls.
// TESTING
//  1. Only req0 reads addr 0x000 -> gnt0 same cycle, rvalid0 next cycle,
//     rdata0 = power-on init byte (low nibble 0xC, high nibble 0x8 -> 0x8C).
//  2. req1 writes 0xA5 to 0xFFF, then reads 0xFFF on the next cycle ->
//     two consecutive gnt1, rvalid1 one cycle after the second, rdata1 = 0xA5.
//  3. req0 and req1 both held high continuously ->
//     four gnt0, then one gnt1, repeating with a 5-cycle period; wait_cnt never exceeds 4.
//  4. Alternating reads: req0 at 0x010 and req1 at 0x020 on adjacent cycles ->
//     rvalid0 and rvalid1 pulse on adjacent cycles with correct data;
//     each rdata holds between its own pulses.
//  5. reset asserted in the cycle after gnt0 for a read -> no rvalid0, rdata0 = 0,
//     and no gnt while reset=1.
//  6. Idle with no requests for 10 cycles -> ram_ce = ram_wre = 0 throughout,
//     and rdata0/rdata1 hold their last values.

Source files
------------

// File: rtl/dpb_port_arbiter_if.sv
// ============================================================================
// Module      : dpb_port_arbiter_if
// Description : Requester and RAM port A signal bundle for dpb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dpb_port_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 8
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          ram_ce;
    logic          ram_oce;
    logic          ram_wre;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  ram_ce, ram_oce, ram_wre, ram_ad, ram_din
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output ram_ce, ram_oce, ram_wre, ram_ad, ram_din
    );
endinterface

`default_nettype wire

// File: rtl/dpb_port_arbiter.sv
// ============================================================================
// Module      : dpb_port_arbiter
// Description : Two-requester arbiter for block RAM port A, CPU priority with
//               aging override for the loader side, 1-cycle tagged read return.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpb_port_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  wire logic             clk,
    input  wire logic             reset,
    dpb_port_arbiter_if.slave     bus
);
    localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_rd_pend;
    logic              r_rd_own;
    logic [DW-1:0]     r_rdata0;
    logic [DW-1:0]     r_rdata1;

    logic              w_force1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_rvalid0;
    logic              w_rvalid1;

    assign w_force1 = (r_wait_cnt == c_MAX_WAIT) && bus.req1;
    assign w_gnt1   = !reset && bus.req1 && (!bus.req0 || w_force1);
    assign w_gnt0   = !reset && bus.req0 && !w_gnt1;

    // RAM output register carries the data during the pulse; the local
    // register holds it afterwards until that port's next return.
    assign w_rvalid0 = !reset && r_rd_pend && !r_rd_own;
    assign w_rvalid1 = !reset && r_rd_pend &&  r_rd_own;

    assign bus.gnt0    = w_gnt0;
    assign bus.gnt1    = w_gnt1;
    assign bus.rvalid0 = w_rvalid0;
    assign bus.rvalid1 = w_rvalid1;
    assign bus.rdata0  = w_rvalid0 ? bus.ram_dout : r_rdata0;
    assign bus.rdata1  = w_rvalid1 ? bus.ram_dout : r_rdata1;

    assign bus.ram_ce  = w_gnt0 || w_gnt1;
    assign bus.ram_oce = 1'b1;
    assign bus.ram_wre = (w_gnt1 && bus.we1) || (w_gnt0 && bus.we0);
    assign bus.ram_ad  = w_gnt1 ? bus.addr1  : bus.addr0;
    assign bus.ram_din = w_gnt1 ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_own   <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            if (!bus.req1 || w_gnt1) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            r_rd_pend <= (w_gnt0 && !bus.we0) || (w_gnt1 && !bus.we1);
            r_rd_own  <= w_gnt1;

            if (w_rvalid0) begin
                r_rdata0 <= bus.ram_dout;
            end
            if (w_rvalid1) begin
                r_rdata1 <= bus.ram_dout;
            end
        end
    end

endmodule

`default_nettype wire
